// File: rtl/bcd_bin_converter.sv
// Sequential 8-digit BCD to two's-complement binary converter (reverse double dabble).
// Ports: clk, rst_n, start, first..eighth, neg -> busy, done, result, err. Option: BCD_BIN_DIGIT_CHECK_EN.
module bcd_bin_converter #(
  parameter int DATA_WIDTH  = 32,
  parameter int DIGIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DIGIT_WIDTH-1:0] first,
  input  logic [DIGIT_WIDTH-1:0] second,
  input  logic [DIGIT_WIDTH-1:0] third,
  input  logic [DIGIT_WIDTH-1:0] fourth,
  input  logic [DIGIT_WIDTH-1:0] fifth,
  input  logic [DIGIT_WIDTH-1:0] sixth,
  input  logic [DIGIT_WIDTH-1:0] seventh,
  input  logic [DIGIT_WIDTH-1:0] eighth,
  input  logic                   neg,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  result,
  output logic                   err
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t state, state_nxt;

  logic [31:0]           bcd_reg;
  logic [DATA_WIDTH-1:0] bin_reg;
  logic [CW-1:0]         cnt;
  logic                  neg_q;

  logic [31:0]           bcd_in;
  logic [31:0]           bcd_shf;
  logic [31:0]           bcd_adj;
  logic [DATA_WIDTH-1:0] bin_shf;
  logic [DATA_WIDTH-1:0] bin_sgn;
  logic                  last;

  assign bcd_in = {eighth, seventh, sixth, fifth,
                   fourth, third, second, first};

  assign last = (cnt == CW'(DATA_WIDTH - 1));

  // One reverse-dabble step: shift right, then digits >= 8 lose 3
  always_comb begin
    bcd_shf = {1'b0, bcd_reg[31:1]};
    bin_shf = {bcd_reg[0], bin_reg[DATA_WIDTH-1:1]};
    bcd_adj = bcd_shf;
    for (int i = 0; i < 8; i++) begin
      if (bcd_shf[4*i+3])
        bcd_adj[4*i +: 4] = bcd_shf[4*i +: 4] - 4'd3;
    end
  end

  assign bin_sgn = neg_q ? (~bin_reg) + DATA_WIDTH'(1) : bin_reg;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = SHIFT;
      SHIFT:  if (last) state_nxt = FINISH;
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  assign busy = (state != IDLE);

`ifdef BCD_BIN_DIGIT_CHECK_EN
  logic bad_in;
  logic flag_q;
  logic err_q;

  always_comb begin
    bad_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) bad_in = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (state == IDLE && start) flag_q <= bad_in;
      if (state == FINISH)        err_q  <= flag_q;
    end
  end

  assign err = err_q;
`else
  logic flag_q;
  assign flag_q = 1'b0;
  assign err    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      neg_q   <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= '0;
            neg_q   <= neg;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_adj;
          bin_reg <= bin_shf;
          cnt     <= cnt + CW'(1);
        end
        FINISH: begin
          result <= flag_q ? '0 : bin_sgn;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
